// File: rtl/demo_qsys_ram_tester_pkg.sv
// Shared types and LFSR helpers for the on-chip RAM self-test master.
package demo_qsys_ram_tester_pkg;

    localparam int unsigned LFSR_W = 32;
    localparam int unsigned ERR_W  = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // One Galois step: shift right, fold the taps back in when a 1 falls out.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/demo_qsys_ram_tester_lfsr.sv
// 32-bit Galois LFSR holding the pattern word for the current test index.
module demo_qsys_ram_tester_lfsr
    import demo_qsys_ram_tester_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_value,
    input  logic              advance,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= LFSR_W'(1);
        end else if (load) begin
            value <= load_value;
        end else if (advance) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/demo_qsys_ram_tester.sv
// Avalon-MM memory self-test: write an LFSR pattern over a window, read it back and compare.
module demo_qsys_ram_tester
    import demo_qsys_ram_tester_pkg::*;
#(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  error_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_waitrequest
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] expected;
        logic [ADDR_W-1:0] addr;
    } rd_entry_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  idx;
    logic [LFSR_W-1:0] seed_q;
    rd_entry_t         pipe [READ_LATENCY];

    logic [LFSR_W-1:0] lfsr_value;
    logic [LFSR_W-1:0] lfsr_load_value_c;
    logic [LFSR_W-1:0] seed_eff_c;
    logic              lfsr_load_c;
    logic              lfsr_adv_c;
    logic              accept_c;
    logic              rd_accept_c;
    logic              last_c;
    logic              mismatch_c;
    logic              drain_busy_c;
    logic [ERR_W-1:0]  err_next_c;

    assign m_byteenable = 4'hF;

    demo_qsys_ram_tester_lfsr u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .load       (lfsr_load_c),
        .load_value (lfsr_load_value_c),
        .advance    (lfsr_adv_c),
        .value      (lfsr_value)
    );

    // Handshake decode and LFSR sequencing: the LFSR always holds the word for idx.
    always_comb begin
        seed_eff_c        = (seed == '0) ? LFSR_W'(1) : seed;
        accept_c          = (m_write | m_read) & ~m_waitrequest;
        rd_accept_c       = m_read & ~m_waitrequest;
        last_c            = (idx + CNT_W'(1)) == count_q;
        lfsr_load_c       = 1'b0;
        lfsr_adv_c        = 1'b0;
        lfsr_load_value_c = seed_q;
        case (state)
            ST_IDLE: begin
                lfsr_load_c       = start;
                lfsr_load_value_c = seed_eff_c;
            end
            ST_WRITE: begin
                lfsr_load_c = accept_c & last_c;
                lfsr_adv_c  = accept_c & ~last_c;
            end
            ST_READ: begin
                lfsr_adv_c = accept_c & ~last_c;
            end
            default: ;
        endcase
    end

    // Compare at the pipeline output; drain ends once only the output stage can hold data.
    always_comb begin
        mismatch_c   = pipe[READ_LATENCY-1].valid &&
                       (m_readdata != pipe[READ_LATENCY-1].expected);
        err_next_c   = error_count;
        if (mismatch_c && (error_count != '1)) begin
            err_next_c = error_count + ERR_W'(1);
        end
        drain_busy_c = 1'b0;
        for (int k = 0; k < int'(READ_LATENCY) - 1; k++) begin
            drain_busy_c = drain_busy_c | pipe[k].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            base_q         <= '0;
            count_q        <= '0;
            idx            <= '0;
            seed_q         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            error_count    <= '0;
            first_err_addr <= '0;
            m_address      <= '0;
            m_chipselect   <= 1'b0;
            m_read         <= 1'b0;
            m_write        <= 1'b0;
            m_writedata    <= '0;
            for (int k = 0; k < int'(READ_LATENCY); k++) begin
                pipe[k] <= '0;
            end
        end else begin
            done    <= 1'b0;
            pipe[0] <= '{valid: rd_accept_c, expected: DATA_W'(lfsr_value), addr: m_address};
            for (int k = 1; k < int'(READ_LATENCY); k++) begin
                pipe[k] <= pipe[k-1];
            end
            error_count <= err_next_c;
            if (mismatch_c && (error_count == '0)) begin
                first_err_addr <= pipe[READ_LATENCY-1].addr;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q         <= base_addr;
                        count_q        <= word_count;
                        seed_q         <= seed_eff_c;
                        idx            <= '0;
                        error_count    <= '0;
                        first_err_addr <= '0;
                        pass           <= 1'b0;
                        if (word_count == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state        <= ST_WRITE;
                            busy         <= 1'b1;
                            m_write      <= 1'b1;
                            m_chipselect <= 1'b1;
                            m_address    <= base_addr;
                            m_writedata  <= DATA_W'(seed_eff_c);
                        end
                    end
                end
                ST_WRITE: begin
                    if (!m_waitrequest) begin
                        if (last_c) begin
                            state     <= ST_READ;
                            idx       <= '0;
                            m_write   <= 1'b0;
                            m_read    <= 1'b1;
                            m_address <= base_q;
                        end else begin
                            idx         <= idx + CNT_W'(1);
                            m_address   <= m_address + ADDR_W'(1);
                            m_writedata <= DATA_W'(lfsr_step(lfsr_value));
                        end
                    end
                end
                ST_READ: begin
                    if (!m_waitrequest) begin
                        if (last_c) begin
                            state        <= ST_DRAIN;
                            m_read       <= 1'b0;
                            m_chipselect <= 1'b0;
                        end else begin
                            idx       <= idx + CNT_W'(1);
                            m_address <= m_address + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!drain_busy_c) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (err_next_c == '0);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demo_qsys_ram_tester.sv
// Bench for demo_qsys_ram_tester: RAM model with fault injection, random stalls, traffic model.
`timescale 1ns/1ps
module tb_demo_qsys_ram_tester;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [31:0] TAPS  = 32'h8020_0003;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic [31:0]   seed;
    logic          busy, done, pass;
    logic [15:0]   error_count;
    logic [AW-1:0] first_err_addr;
    logic [AW-1:0] m_address;
    logic [3:0]    m_byteenable;
    logic          m_chipselect, m_read, m_write;
    logic [31:0]   m_writedata;
    logic [31:0]   m_readdata;
    logic          m_waitrequest;

    demo_qsys_ram_tester #(.ADDR_W(AW), .DATA_W(32), .READ_LATENCY(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .error_count    (error_count),
        .first_err_addr (first_err_addr),
        .m_address      (m_address),
        .m_byteenable   (m_byteenable),
        .m_chipselect   (m_chipselect),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_writedata    (m_writedata),
        .m_readdata     (m_readdata),
        .m_waitrequest  (m_waitrequest)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // RAM slave, read latency 1, optional bit-0 corruption on one address
    logic [31:0]   mem [DEPTH];
    bit            flip_en = 1'b0;
    logic [AW-1:0] flip_addr = '0;
    bit            stall_en = 1'b0;

    always @(posedge clk) begin
        if (m_chipselect && m_write && !m_waitrequest) mem[m_address] <= m_writedata;
        if (m_chipselect && m_read && !m_waitrequest)
            m_readdata <= mem[m_address] ^ ((flip_en && m_address == flip_addr) ? 32'h1 : 32'h0);
    end

    initial begin
        m_waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            m_waitrequest = stall_en && ($urandom_range(0, 99) < 30);
        end
    end

    // Bus monitor: accepted transfers, request stability during stalls, chipselect rule
    int unsigned   cyc = 0;
    bit            mon_on = 1'b0;
    logic [AW-1:0] wr_addr_q[$];
    logic [AW-1:0] rd_addr_q[$];
    logic [31:0]   wr_data_q[$];
    int unsigned   wr_first, wr_last;
    int unsigned   req_count = 0;
    int unsigned   stall_viol = 0;
    int unsigned   cs_viol = 0;
    logic          prev_stall = 1'b0;
    logic [AW+33:0] prev_req = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_chipselect != (m_read | m_write)) cs_viol <= cs_viol + 1;
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && ({m_read, m_write, m_address, m_writedata} != prev_req))
                stall_viol <= stall_viol + 1;
            prev_stall <= (m_read | m_write) && m_waitrequest;
            prev_req   <= {m_read, m_write, m_address, m_writedata};
        end
        if (mon_on) begin
            if (m_read | m_write) req_count <= req_count + 1;
            if (m_write && !m_waitrequest) begin
                if (wr_addr_q.size() == 0) wr_first <= cyc;
                wr_last <= cyc;
                wr_addr_q.push_back(m_address);
                wr_data_q.push_back(m_writedata);
            end
            if (m_read && !m_waitrequest) rd_addr_q.push_back(m_address);
        end
    end

    typedef struct {
        int unsigned base;
        int unsigned count;
        int unsigned seed;
        bit          flip_en;
        int unsigned flip_addr;
        bit          stall;
        bit          exp_pass;
        int unsigned exp_err;
        int unsigned exp_first;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input vec_t v, input int id);
        logic [31:0]   x;
        logic [AW-1:0] a;
        int unsigned   wr_bad, rd_bad;
        bit            seen;
        string         tag;
        tag = $sformatf("v%0d", id);
        @(negedge clk);
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        req_count = 0; stall_viol = 0; cs_viol = 0;
        flip_en    = v.flip_en;
        flip_addr  = AW'(v.flip_addr);
        stall_en   = v.stall;
        base_addr  = AW'(v.base);
        word_count = (AW+1)'(v.count);
        seed       = v.seed;
        start      = 1'b1;
        mon_on     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        stall_en = 1'b0;
        check({tag, "_done_seen"}, 64'(seen), 64'(1));
        check({tag, "_pass"}, 64'(pass), 64'(v.exp_pass));
        check({tag, "_error_count"}, 64'(error_count), 64'(v.exp_err));
        check({tag, "_first_err_addr"}, 64'(first_err_addr), 64'(v.exp_first));
        // expected traffic: word i at (base+i) mod depth carries seed stepped i times
        x = (v.seed == 0) ? 32'h1 : v.seed;
        wr_bad = (wr_addr_q.size() == v.count) ? 0 : 1;
        rd_bad = (rd_addr_q.size() == v.count) ? 0 : 1;
        for (int i = 0; i < int'(v.count); i++) begin
            a = AW'((v.base + i) % DEPTH);
            if (i < wr_addr_q.size() && (wr_addr_q[i] != a || wr_data_q[i] != x)) wr_bad++;
            if (i < rd_addr_q.size() && rd_addr_q[i] != a) rd_bad++;
            x = (x >> 1) ^ (x[0] ? TAPS : 32'h0);
        end
        check({tag, "_write_seq_errors"}, 64'(wr_bad), 64'(0));
        check({tag, "_read_seq_errors"}, 64'(rd_bad), 64'(0));
        if (!v.stall) check({tag, "_write_span"}, 64'(wr_last - wr_first), 64'(v.count - 1));
        check({tag, "_protocol_viol"}, 64'(stall_viol + cs_viol), 64'(0));
        @(negedge clk);
        mon_on = 1'b0;
        check({tag, "_after_done"}, 64'({done, busy}), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned b, c, off, fa;
        bit          seen;

        vecs.push_back('{0,    16,   1,            0, 0, 0, 1, 0, 0});
        vecs.push_back('{0,    16,   1,            1, 5, 0, 0, 1, 5});
        vecs.push_back('{1020, 8,    32'hDEADBEEF, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{0,    1024, 0,            0, 0, 1, 1, 0, 0});
        for (int r = 0; r < 3; r++) begin
            b   = $urandom_range(0, DEPTH - 1);
            c   = $urandom_range(1, 64);
            off = $urandom_range(0, c - 1);
            fa  = (b + off) % DEPTH;
            vecs.push_back('{b, c, $urandom, 1, fa, 1'($urandom_range(0, 1)), 0, 1, fa});
        end

        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; seed = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_status", 64'({busy, done, pass, error_count, first_err_addr}), 64'(0));
        check("reset_bus", 64'({m_read, m_write, m_chipselect, m_address, m_writedata}), 64'(0));
        check("byteenable", 64'(m_byteenable), 64'(4'hF));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // zero-length window straight after a failing run
        @(negedge clk);
        req_count = 0; base_addr = AW'(5); word_count = '0; seed = 32'h1234; start = 1'b1; mon_on = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("zero_done", 64'(done), 64'(1));
        check("zero_pass", 64'(pass), 64'(1));
        check("zero_error_count", 64'(error_count), 64'(0));
        check("zero_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        check("zero_done_pulse", 64'(done), 64'(0));
        mon_on = 1'b0;
        check("zero_no_requests", 64'(req_count), 64'(0));

        // reset in the middle of the read phase, after one mismatch has been counted
        @(negedge clk);
        flip_en = 1'b1; flip_addr = AW'(100);
        base_addr = AW'(100); word_count = (AW+1)'(64); seed = 32'h7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (m_read) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mid_reset_reached_read", 64'(seen), 64'(1));
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_status", 64'({busy, done, pass, error_count, first_err_addr}), 64'(0));
        check("mid_reset_bus", 64'({m_read, m_write, m_chipselect, m_address, m_writedata}), 64'(0));
        @(negedge clk);
        reset   = 1'b0;
        flip_en = 1'b0;
        seen    = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done || busy || m_read || m_write) seen = 1'b1;
        end
        check("mid_reset_idle_quiet", 64'(seen), 64'(0));
        run_vec('{100, 64, 7, 0, 0, 0, 1, 0, 0}, 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
